// File: rtl/gpr_retire_wakeup_gen_pkg.sv
// Shared issue-stage constants for the GPR retire wakeup generator.
// These mirror the global/issue definition values so that every file in this
// slice pulls widths from one place instead of redefining them locally.
package gpr_retire_wakeup_gen_pkg;

  // Wavefront slots per compute unit.
  localparam int WF_PER_CU                = 40;
  // Wavefront id width.
  localparam int WF_ID_LENGTH             = 6;
  // Operand slots tracked per decoded instruction.
  localparam int ISSUE_GPR_RD_BITS_LENGTH = 8;
  // Register address widths for the two register files.
  localparam int VGPR_ADDR_W              = 10;
  localparam int SGPR_ADDR_W              = 9;

endpackage : gpr_retire_wakeup_gen_pkg

// File: rtl/gpr_retire_wakeup_gen_match.sv
// Operand-slot comparator for one dependency-table entry.
// A slot matches when it is still pending and its register equals the retiring
// register, or (for a 64-bit write) the register right after it. The +1 term
// is computed one bit wider so the top register never wraps onto address 0.
module gpr_retire_match
  import gpr_retire_wakeup_gen_pkg::*;
#(
  parameter int OPND   = ISSUE_GPR_RD_BITS_LENGTH,
  parameter int ADDR_W = VGPR_ADDR_W
) (
  input  logic [OPND-1:0]        pend,
  input  logic [OPND*ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0]      retire_addr,
  input  logic                   retire_dword2,
  output logic [OPND-1:0]        match
);

  logic [ADDR_W:0] addr_p1;

  assign addr_p1 = {1'b0, retire_addr} + {{ADDR_W{1'b0}}, 1'b1};

  for (genvar k = 0; k < OPND; k++) begin : g_slot
    logic [ADDR_W-1:0] slot_addr;
    logic              lo_hit;
    logic              hi_hit;

    assign slot_addr = addr[k*ADDR_W +: ADDR_W];
    assign lo_hit    = (slot_addr == retire_addr);
    assign hi_hit    = retire_dword2 && ({1'b0, slot_addr} == addr_p1);
    assign match[k]  = pend[k] && (lo_hit || hi_hit);
  end

endmodule : gpr_retire_match

// File: rtl/gpr_retire_wakeup_gen.sv
// Retire wakeup generator for one writeback port.
// Keeps, per wavefront, the register addresses and pending bits of the decoded
// but not yet issued instruction, matches each retiring write against them and
// emits a registered ready-set vector for the issue-stage dependency table.
//
// Handshake: all inputs are valid-only strobes (no ready/backpressure). A
// strobe is consumed on the rising clock edge where its *_valid is high; the
// block can always accept decode, issue and retire in the same cycle.
// set_data is a one-cycle pulse; set_wfid is meaningful only while
// set_data != 0 and otherwise holds its last value.
module gpr_retire_wakeup_gen
  import gpr_retire_wakeup_gen_pkg::*;
#(
  parameter int WF_PER_CU_P = WF_PER_CU,
  parameter int WFID_W      = WF_ID_LENGTH,
  parameter int OPND        = ISSUE_GPR_RD_BITS_LENGTH,
  parameter int ADDR_W      = VGPR_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   decode_valid,
  input  logic [WFID_W-1:0]      decode_wfid,
  input  logic [OPND*ADDR_W-1:0] decode_addr,
  input  logic [OPND-1:0]        decode_pending,
  input  logic                   issue_valid,
  input  logic [WFID_W-1:0]      issue_wfid,
  input  logic                   retire_valid,
  input  logic [WFID_W-1:0]      retire_wfid,
  input  logic [ADDR_W-1:0]      retire_addr,
  input  logic                   retire_dword2,
  output logic [OPND-1:0]        set_data,
  output logic [WFID_W-1:0]      set_wfid
);

  // Entry storage
  logic [WF_PER_CU_P-1:0][OPND-1:0]        pend_q, pend_d;
  logic [WF_PER_CU_P-1:0][OPND*ADDR_W-1:0] addr_q, addr_d;

  // Output registers
  logic [OPND-1:0]   set_data_q, set_data_d;
  logic [WFID_W-1:0] set_wfid_q, set_wfid_d;

  // Entry selected by the retiring wavefront
  logic [OPND-1:0]        rd_pend;
  logic [OPND*ADDR_W-1:0] rd_addr;

  logic [OPND-1:0] match_tab;
  logic [OPND-1:0] match_byp;
  logic            byp_sel;
  logic [OPND-1:0] hit_vec;

  // Read mux: pick the entry of the retiring wavefront (zero if out of range).
  always_comb begin
    rd_pend = '0;
    rd_addr = '0;
    for (int w = 0; w < WF_PER_CU_P; w++) begin
      if (retire_wfid == WFID_W'(w)) begin
        rd_pend = pend_q[w];
        rd_addr = addr_q[w];
      end
    end
  end

  // Compare the retiring write against the stored entry.
  gpr_retire_match #(
    .OPND   (OPND),
    .ADDR_W (ADDR_W)
  ) u_match_tab (
    .pend          (rd_pend),
    .addr          (rd_addr),
    .retire_addr   (retire_addr),
    .retire_dword2 (retire_dword2),
    .match         (match_tab)
  );

  // Compare the retiring write against the operands being decoded right now,
  // so a write that lands in the decode cycle is not lost.
  gpr_retire_match #(
    .OPND   (OPND),
    .ADDR_W (ADDR_W)
  ) u_match_byp (
    .pend          (decode_pending),
    .addr          (decode_addr),
    .retire_addr   (retire_addr),
    .retire_dword2 (retire_dword2),
    .match         (match_byp)
  );

  // Select the wakeup vector: bypass path when decode hits the same wavefront.
  always_comb begin
    byp_sel = decode_valid && retire_valid && (decode_wfid == retire_wfid);
    hit_vec = '0;
    if (retire_valid) begin
      hit_vec = byp_sel ? match_byp : match_tab;
    end
  end

  // Next-state for entries: decode beats issue beats retire-clear per wavefront.
  always_comb begin
    pend_d = pend_q;
    addr_d = addr_q;
    for (int w = 0; w < WF_PER_CU_P; w++) begin
      if (decode_valid && (decode_wfid == WFID_W'(w))) begin
        addr_d[w] = decode_addr;
        pend_d[w] = decode_pending & ~(byp_sel ? match_byp : '0);
      end else if (issue_valid && (issue_wfid == WFID_W'(w))) begin
        pend_d[w] = '0;
      end else if (retire_valid && (retire_wfid == WFID_W'(w))) begin
        pend_d[w] = pend_q[w] & ~match_tab;
      end
    end
  end

  // Next-state for outputs: wfid only advances on a real wakeup.
  always_comb begin
    set_data_d = hit_vec;
    set_wfid_d = set_wfid_q;
    if (|hit_vec) begin
      set_wfid_d = retire_wfid;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q     <= '0;
      addr_q     <= '0;
      set_data_q <= '0;
      set_wfid_q <= '0;
    end else begin
      pend_q     <= pend_d;
      addr_q     <= addr_d;
      set_data_q <= set_data_d;
      set_wfid_q <= set_wfid_d;
    end
  end

  assign set_data = set_data_q;
  assign set_wfid = set_wfid_q;

endmodule : gpr_retire_wakeup_gen
